// File: rtl/flags_ctl_pkg.sv
// flags_ctl_pkg: shared bit positions, opcodes and FSM encoding for flags_ctl.
`ifndef CMD_CLC
`define CMD_CLC   6'h01
`define CMD_STC   6'h02
`define CMD_CMC   6'h03
`define CMD_CLD   6'h04
`define CMD_STD   6'h05
`define CMD_LAHF  6'h06
`define CMD_SAHF  6'h07
`define CMD_PUSHF 6'h08
`define CMD_POPF  6'h09
`endif

package flags_ctl_pkg;
  localparam int OF_BIT = 6;
  localparam int SF_BIT = 5;
  localparam int CF_BIT = 4;
  localparam int ZF_BIT = 3;
  localparam int AF_BIT = 2;
  localparam int PF_BIT = 1;
  localparam int IF_BIT = 0;

  localparam int IMG_CF  = 0;
  localparam int IMG_ONE = 1;
  localparam int IMG_PF  = 2;
  localparam int IMG_AF  = 4;
  localparam int IMG_ZF  = 6;
  localparam int IMG_SF  = 7;
  localparam int IMG_IF  = 9;
  localparam int IMG_DF  = 10;
  localparam int IMG_OF  = 11;

  localparam int LAHF_CF  = 0;
  localparam int LAHF_ONE = 1;
  localparam int LAHF_PF  = 2;
  localparam int LAHF_AF  = 4;
  localparam int LAHF_ZF  = 6;
  localparam int LAHF_SF  = 7;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MEM_WR = 2'd1;
  localparam logic [1:0] S_MEM_RD = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    MEM_WR = S_MEM_WR,
    MEM_RD = S_MEM_RD,
    RESP   = S_RESP
  } state_t;
endpackage

// File: rtl/flags_ctl_image.sv
// flags_image: packs status+DF into the x86 flag image and LAHF byte, and unpacks an image.
module flags_image
  import flags_ctl_pkg::*;
#(
  parameter int IMG_W = 16
) (
  input  logic [6:0]       status,
  input  logic             df,
  input  logic [IMG_W-1:0] src,
  output logic [IMG_W-1:0] image,
  output logic [7:0]       lahf,
  output logic [6:0]       src_status,
  output logic             src_df
);
  logic unused_src;
  assign unused_src = ^src;
  always_comb begin
    image = '0;
    image[IMG_CF] = status[CF_BIT];
    image[IMG_ONE] = 1'b1;
    image[IMG_PF] = status[PF_BIT];
    image[IMG_AF] = status[AF_BIT];
    image[IMG_ZF] = status[ZF_BIT];
    image[IMG_SF] = status[SF_BIT];
    image[IMG_IF] = status[IF_BIT];
    image[IMG_DF] = df;
    image[IMG_OF] = status[OF_BIT];
    lahf = '0;
    lahf[LAHF_CF] = status[CF_BIT];
    lahf[LAHF_ONE] = 1'b1;
    lahf[LAHF_PF] = status[PF_BIT];
    lahf[LAHF_AF] = status[AF_BIT];
    lahf[LAHF_ZF] = status[ZF_BIT];
    lahf[LAHF_SF] = status[SF_BIT];
    src_status = '0;
    src_status[OF_BIT] = src[IMG_OF];
    src_status[SF_BIT] = src[IMG_SF];
    src_status[CF_BIT] = src[IMG_CF];
    src_status[ZF_BIT] = src[IMG_ZF];
    src_status[AF_BIT] = src[IMG_AF];
    src_status[PF_BIT] = src[IMG_PF];
    src_status[IF_BIT] = src[IMG_IF];
    src_df = src[IMG_DF];
  end
endmodule

// File: rtl/flags_ctl.sv
// flags_ctl: architectural flag register with flag-meta commands and masked ALU writes.
// Define FLAGS_PUSHPOP_EN to include the PUSHF/POPF memory FSM with timeout.
module flags_ctl
  import flags_ctl_pkg::*;
#(
  parameter int OPC_W       = 6,
  parameter int STATUS_W    = 7,
  parameter int IMG_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OPC_W-1:0]    cmd_opc,
  input  logic [7:0]          ah_in,
  input  logic                alu_wr,
  input  logic [STATUS_W-1:0] alu_mask,
  input  logic [STATUS_W-1:0] alu_status,
  output logic [STATUS_W-1:0] status_out,
  output logic                df_out,
  output logic                ah_wr,
  output logic [7:0]          ah_out,
  output logic                done,
  output logic                err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [IMG_W-1:0]    mem_wdata,
  input  logic [IMG_W-1:0]    mem_rdata,
  input  logic                mem_ack
);
  state_t state, state_nx;
  logic [STATUS_W-1:0] status, status_nx;
  logic [6:0] cmd_we, cmd_v, img_st;
  logic df, df_nx, img_df, ah_wr_nx, err_nx, accept;
  logic [IMG_W-1:0] image;
  logic [7:0] lahf;
  logic unused_ah;

  flags_image #(.IMG_W(IMG_W)) u_image (
    .status(status[6:0]), .df(df), .src(mem_rdata),
    .image(image), .lahf(lahf), .src_status(img_st), .src_df(img_df)
  );

  assign unused_ah = ^{ah_in[5], ah_in[3], ah_in[1]};
  assign done = state == RESP;
  assign cmd_ready = state == IDLE && !done;
  assign accept = cmd_valid && cmd_ready;
  assign status_out = status;
  assign df_out = df;

`ifdef FLAGS_PUSHPOP_EN
  logic [7:0] cnt;
  logic in_mem;
  assign in_mem = state == MEM_WR || state == MEM_RD;
  assign mem_req = in_mem;
  assign mem_we = state == MEM_WR;
`else
  logic unused_mem;
  assign unused_mem = ^{mem_ack, img_st, img_df};
  assign mem_req = 1'b0;
  assign mem_we = 1'b0;
  assign mem_wdata = '0;
`endif

  always_comb begin
    state_nx = state == RESP ? IDLE : state;
    cmd_we = '0;
    cmd_v = '0;
    df_nx = df;
    ah_wr_nx = 1'b0;
    err_nx = 1'b0;
    if (accept) begin
      state_nx = RESP;
      case (cmd_opc)
        `CMD_CLC: cmd_we[CF_BIT] = 1'b1;
        `CMD_STC: begin cmd_we[CF_BIT] = 1'b1; cmd_v[CF_BIT] = 1'b1; end
        `CMD_CMC: begin cmd_we[CF_BIT] = 1'b1; cmd_v[CF_BIT] = !status[CF_BIT]; end
        `CMD_CLD: df_nx = 1'b0;
        `CMD_STD: df_nx = 1'b1;
        `CMD_LAHF: ah_wr_nx = 1'b1;
        `CMD_SAHF: begin
          cmd_we = 7'b0111110;
          cmd_v[SF_BIT] = ah_in[7];
          cmd_v[ZF_BIT] = ah_in[6];
          cmd_v[AF_BIT] = ah_in[4];
          cmd_v[PF_BIT] = ah_in[2];
          cmd_v[CF_BIT] = ah_in[0];
        end
`ifdef FLAGS_PUSHPOP_EN
        `CMD_PUSHF: state_nx = MEM_WR;
        `CMD_POPF: state_nx = MEM_RD;
`endif
        default: err_nx = 1'b1;
      endcase
    end
`ifdef FLAGS_PUSHPOP_EN
    // an ack on the limit cycle still completes the transfer
    if (in_mem && mem_ack) begin
      state_nx = RESP;
      if (state == MEM_RD) begin cmd_we = '1; cmd_v = img_st; df_nx = img_df; end
    end else if (in_mem && cnt == 8'(MEM_TIMEOUT)) begin
      state_nx = RESP;
      err_nx = 1'b1;
    end
`endif
    status_nx = alu_wr ? (status & ~alu_mask) | (alu_status & alu_mask) : status;
    status_nx[6:0] = (status_nx[6:0] & ~cmd_we) | (cmd_v & cmd_we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      status <= '0;
      df <= 1'b0;
      ah_wr <= 1'b0;
      ah_out <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      status <= status_nx;
      df <= df_nx;
      ah_wr <= ah_wr_nx;
      err <= err_nx;
      if (ah_wr_nx) ah_out <= lahf;
    end
  end

`ifdef FLAGS_PUSHPOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wdata <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && state_nx == MEM_WR) mem_wdata <= image;
      cnt <= (in_mem && state_nx == state) ? cnt + 8'd1 : '0;
    end
  end
`endif
endmodule

// File: tb/tb_flags_ctl.sv
// tb_flags_ctl: directed self-checking bench for flags_ctl (honours FLAGS_PUSHPOP_EN).
module tb_flags_ctl;
  logic clk = 1'b0;
  logic rst_n, cmd_valid, cmd_ready, alu_wr, df_out, ah_wr, done, err;
  logic mem_req, mem_we, mem_ack;
  logic [5:0] cmd_opc;
  logic [7:0] ah_in, ah_out;
  logic [6:0] alu_mask, alu_status, status_out;
  logic [15:0] mem_wdata, mem_rdata;
  int checks = 0;
  int failures = 0;

  flags_ctl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opc(cmd_opc), .ah_in(ah_in), .alu_wr(alu_wr), .alu_mask(alu_mask),
    .alu_status(alu_status), .status_out(status_out), .df_out(df_out),
    .ah_wr(ah_wr), .ah_out(ah_out), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // drive at a negedge, return at the negedge after the accept edge
  task automatic issue(input logic [5:0] opc, input logic [7:0] ah);
    cmd_valid = 1'b1;
    cmd_opc = opc;
    ah_in = ah;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opc = '0; ah_in = '0;
    alu_wr = 1'b0; alu_mask = '0; alu_status = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_status", status_out, 7'h00);
    chk("rst_df", df_out, 1'b0);
    chk("rst_done", {done, err, ah_wr, mem_req, mem_we}, 5'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    issue(`CMD_STC, 8'h00);
    chk("stc_status", status_out, 7'h10);
    chk("stc_done", {done, err}, 2'b10);
    chk("resp_ready", cmd_ready, 1'b0);
    @(negedge clk);
    issue(`CMD_CMC, 8'h00);
    chk("cmc_status", status_out, 7'h00);
    @(negedge clk);
    issue(`CMD_LAHF, 8'h00);
    chk("lahf_ah", ah_out, 8'h02);
    chk("lahf_strobe", {ah_wr, done, err}, 3'b110);
    @(negedge clk);
    chk("lahf_pulse_end", {ah_wr, done}, 2'b00);
    issue(`CMD_STD, 8'h00);
    chk("std_df", df_out, 1'b1);
    @(negedge clk);

`ifdef FLAGS_PUSHPOP_EN
    issue(`CMD_PUSHF, 8'h00);
    chk("push_req", {mem_req, mem_we, cmd_ready}, 3'b110);
    chk("push_wdata0", mem_wdata, 16'h0402);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("push_wdata_hold", {mem_req, mem_wdata}, {1'b1, 16'h0402});
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("push_done", {mem_req, done, err}, 3'b010);
    chk("push_df", df_out, 1'b1);
    @(negedge clk);

    mem_rdata = 16'h08C1;
    issue(`CMD_POPF, 8'h00);
    chk("pop_req", {mem_req, mem_we, cmd_ready}, 3'b100);
    @(negedge clk);
    chk("pop_wait_ready", cmd_ready, 1'b0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("pop_status", status_out, 7'h78);
    chk("pop_df", df_out, 1'b0);
    chk("pop_done", {done, err}, 2'b10);
    @(negedge clk);
`else
    issue(`CMD_PUSHF, 8'h00);
    chk("push_off_done", {done, err, mem_req}, 3'b110);
    chk("push_off_flags", {df_out, status_out}, {1'b1, 7'h00});
    @(negedge clk);
    issue(`CMD_POPF, 8'h00);
    chk("pop_off_done", {done, err, mem_req}, 3'b110);
    @(negedge clk);
`endif

    alu_wr = 1'b1; alu_mask = 7'h50; alu_status = 7'h00;
    issue(`CMD_SAHF, 8'hD5);
    alu_wr = 1'b0;
    chk("sahf_status", status_out, 7'h3E);
    @(negedge clk);
    issue(6'h3F, 8'h00);
    chk("bad_opc", {done, err, status_out}, {2'b11, 7'h3E});
    @(negedge clk);

`ifdef FLAGS_PUSHPOP_EN
    begin
      int n = 0;
      issue(`CMD_PUSHF, 8'h00);
      while (mem_req && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk("timeout_cycles", n, 16);
      chk("timeout_done", {done, err, mem_req}, 3'b110);
      chk("timeout_flags", {df_out, status_out}, {1'b0, 7'h3E});
      @(negedge clk);
    end
`endif

    issue(`CMD_CLC, 8'h00);
    chk("clc_after", {done, err, status_out}, {2'b10, 7'h2E});
    @(negedge clk);
    alu_wr = 1'b1; alu_mask = 7'h41; alu_status = 7'h41;
    @(negedge clk);
    alu_wr = 1'b0;
    chk("alu_only", status_out, 7'h6F);

`ifdef FLAGS_PUSHPOP_EN
    begin
      logic seen = 1'b0;
      issue(`CMD_POPF, 8'h00);
      chk("mid_req", mem_req, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_req", mem_req, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        seen |= done;
        @(negedge clk);
      end
      chk("mid_rst_nodone", seen, 1'b0);
      chk("mid_rst_status", {df_out, status_out}, 8'h00);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
